// File: rtl/gelato_l1_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gelato_l1_cache_ctrl
// Brief   : Blocking read-only direct-mapped L1 cache controller with warp tags.
//           Optional hit/miss counters: define GELATO_L1_CACHE_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module gelato_l1_cache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BITS  = 512,
  parameter int NUM_LINES  = 64,
  parameter int WARP_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WARP_W-1:0]     req_warp,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [WARP_W-1:0]     resp_warp,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [LINE_BITS-1:0]  mem_resp_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int c_off_w  = $clog2(LINE_BITS / 8);
  localparam int c_idx_w  = $clog2(NUM_LINES);
  localparam int c_tag_w  = ADDR_WIDTH - c_idx_w - c_off_w;
  localparam int c_bsel_w = $clog2(DATA_WIDTH / 8);
  localparam int c_wsel_w = c_off_w - c_bsel_w;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [c_tag_w-1:0]    r_tag;
  logic [c_idx_w-1:0]    r_idx;
  logic [c_wsel_w-1:0]   r_wsel;
  logic [WARP_W-1:0]     r_warp;
  logic [NUM_LINES-1:0]  r_valid;
  logic [c_tag_w-1:0]    r_tag_mem  [NUM_LINES];
  logic [LINE_BITS-1:0]  r_line_mem [NUM_LINES];
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic [WARP_W-1:0]     r_resp_warp;
  logic                  r_mem_req_valid;
  logic [ADDR_WIDTH-1:0] r_mem_req_addr;

  logic                  w_accept;
  logic                  w_hit;
  logic                  w_fill;
  logic                  w_lookup;
  logic [LINE_BITS-1:0]  w_hit_line;
  logic [DATA_WIDTH-1:0] w_hit_word;
  logic [DATA_WIDTH-1:0] w_fill_word;
  logic                  w_unused_bsel;

  // Flush wins over a coincident request by masking ready combinationally.
  assign req_ready     = r_ready & ~flush;
  assign w_accept      = req_valid & req_ready;
  assign w_lookup      = (r_state == ST_LOOKUP);
  assign w_hit         = r_valid[r_idx] && (r_tag_mem[r_idx] == r_tag);
  assign w_fill        = (r_state == ST_MEM_WAIT) && mem_resp_valid;
  assign w_hit_line    = r_line_mem[r_idx];
  assign w_hit_word    = w_hit_line[r_wsel * DATA_WIDTH +: DATA_WIDTH];
  assign w_fill_word   = mem_resp_data[r_wsel * DATA_WIDTH +: DATA_WIDTH];
  assign w_unused_bsel = ^req_addr[c_bsel_w-1:0];

  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign resp_warp     = r_resp_warp;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_ready         <= 1'b0;
      r_valid         <= '0;
      r_tag           <= '0;
      r_idx           <= '0;
      r_wsel          <= '0;
      r_warp          <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_resp_warp     <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (flush) begin
            r_valid <= '0;
          end else if (w_accept) begin
            r_tag   <= req_addr[ADDR_WIDTH-1:c_idx_w+c_off_w];
            r_idx   <= req_addr[c_idx_w+c_off_w-1:c_off_w];
            r_wsel  <= req_addr[c_off_w-1:c_bsel_w];
            r_warp  <= req_warp;
            r_ready <= 1'b0;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_resp_data  <= w_hit_word;
            r_resp_warp  <= r_warp;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_mem_req_addr  <= {r_tag, r_idx, {c_off_w{1'b0}}};
            r_mem_req_valid <= 1'b1;
            r_state         <= ST_MEM_REQ;
          end
        end
        ST_MEM_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          // Respond straight from the fill beat; the array write lands this edge too.
          if (mem_resp_valid) begin
            r_valid[r_idx] <= 1'b1;
            r_resp_data    <= w_fill_word;
            r_resp_warp    <= r_warp;
            r_resp_valid   <= 1'b1;
            r_state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fill) begin
      r_tag_mem[r_idx]  <= r_tag;
      r_line_mem[r_idx] <= mem_resp_data;
    end
  end

`ifdef GELATO_L1_CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_lookup) begin
      if (w_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end else begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  logic w_unused_lookup;
  assign w_unused_lookup = w_lookup;
  assign hit_count       = 32'd0;
  assign miss_count      = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gelato_l1_cache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_gelato_l1_cache_ctrl
// Brief   : Randomized self-checking bench for gelato_l1_cache_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gelato_l1_cache_ctrl;

  localparam int NL = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [3:0]   req_warp;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [3:0]   resp_warp;
  logic         flush;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [511:0] mem_resp_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  always #5 clk = ~clk;

  gelato_l1_cache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_warp       (req_warp),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_warp      (resp_warp),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          m_valid [NL];
  logic [19:0] m_tag   [NL];
  int          m_hits  = 0;
  int          m_misses = 0;
  logic [31:0] last_data;
  bit          last_miss;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Backing memory: word k of the line at address la.
  function automatic logic [31:0] line_word(input logic [31:0] la, input int k);
    return (la ^ 32'hA000_1040) + 32'(k);
  endfunction

  function automatic logic [511:0] line_of(input logic [31:0] la);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = line_word(la, k);
    return l;
  endfunction

  function automatic logic [511:0] junk_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef GELATO_L1_CACHE_STATS_EN
    check_val({tag, "_hits"},   hit_count,  32'(m_hits));
    check_val({tag, "_misses"}, miss_count, 32'(m_misses));
`else
    check_val({tag, "_hits"},   hit_count,  32'd0);
    check_val({tag, "_misses"}, miss_count, 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    @(negedge clk);
  endtask

  // One complete read transaction, starting and ending on a negedge.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] warp,
                         input int mstall, input int rstall);
    logic [5:0]  idx;
    logic [19:0] tg;
    logic [31:0] la, exp_word, a0, d0;
    bit          exp_hit;
    int          n;
    idx      = addr[11:6];
    tg       = addr[31:12];
    la       = {addr[31:6], 6'd0};
    exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
    exp_word = line_word(la, int'(addr[5:2]));

    req_valid = 1'b1; req_addr = addr; req_warp = warp;
    n = 0;
    #1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check_val("accept_wait", 64'(n < 20), 64'd1);
    if (n >= 20) begin do_reset(); return; end
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_warp = 4'($urandom);
    check_val("lookup_quiet", {resp_valid, mem_req_valid, req_ready}, 3'b000);
    @(negedge clk);
    last_miss = ~resp_valid;
    check_val("path", {resp_valid, mem_req_valid}, exp_hit ? 2'b10 : 2'b01);
    if (!resp_valid && !mem_req_valid) begin do_reset(); return; end

    if (!resp_valid) begin
      a0 = mem_req_addr;
      check_val("mreq_addr", a0, la);
      for (int i = 0; i < mstall; i++) begin
        mem_resp_valid = 1'b1; mem_resp_data = junk_line();
        @(negedge clk);
        check_val("mreq_hold", {mem_req_valid, req_ready, resp_valid, mem_req_addr},
                  {3'b100, a0});
      end
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check_val("mreq_drop", mem_req_valid, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_val("wait_quiet", resp_valid, 1'b0);
      end
      mem_resp_valid = 1'b1; mem_resp_data = line_of(la);
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_resp_data = junk_line();
      check_val("fill_lat", resp_valid, 1'b1);
      if (!resp_valid) begin do_reset(); return; end
    end

    d0 = resp_data;
    last_data = d0;
    check_val("resp_data", d0, exp_word);
    check_val("resp_warp", resp_warp, warp);
    for (int i = 0; i < rstall; i++) begin
      @(negedge clk);
      check_val("resp_hold", {resp_valid, req_ready, resp_data, resp_warp}, {2'b10, d0, warp});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_val("b2b_ready", {resp_valid, req_ready}, 2'b01);

    if (exp_hit) m_hits++;
    else begin
      m_misses++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
  endtask

  task automatic do_flush(input bit with_req);
    flush = 1'b1; req_valid = with_req; req_addr = $urandom; req_warp = 4'($urandom);
    #1;
    check_val("flush_ready", req_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    model_clear();
    repeat (2) begin
      #1;
      check_val("flush_idle", {req_ready, mem_req_valid, resp_valid}, 3'b100);
      @(negedge clk);
    end
  endtask

  task automatic reset_in_mem_wait();
    int n;
    req_valid = 1'b1; req_addr = 32'h0000_3080; req_warp = 4'd9;
    n = 0;
    #1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 10) begin @(negedge clk); n++; end
    check_val("rmw_mreq", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = line_of(32'h0000_3080);
    #1;
    check_val("rmw_rst_ready", req_ready, 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    repeat (3) begin
      check_val("rmw_idle", {resp_valid, mem_req_valid, req_ready}, 3'b001);
      @(negedge clk);
    end
    check_stats("rmw");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_warp = '0;
    resp_ready = 1'b0; flush = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(negedge clk);
    check_val("rst_flags", {req_ready, resp_valid, mem_req_valid}, 3'b000);
    check_val("rst_resp",  {resp_data, resp_warp}, 36'd0);
    check_val("rst_maddr", mem_req_addr, 32'd0);
    check_stats("rst");
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check_val("rst_ready1", req_ready, 1'b1);

    do_read(32'h0000_1044, 4'd3, 0, 0);
    check_val("cold_miss", last_miss, 1'b1);
    check_val("cold_word", last_data, 32'hA000_0001);
    do_read(32'h0000_1048, 4'd5, 0, 0);
    check_val("hit_nomiss", last_miss, 1'b0);
    check_val("hit_word", last_data, 32'hA000_0002);
    do_read(32'h0000_2040, 4'd1, 1, 0);
    check_val("conflict_miss", last_miss, 1'b1);
    do_read(32'h0000_1040, 4'd2, 0, 1);
    check_val("evict_remiss", last_miss, 1'b1);
    do_read(32'h0000_5004, 4'd7, 5, 4);
    do_read(32'h0000_5004, 4'd7, 0, 4);
    check_val("bp_hit", last_miss, 1'b0);
    do_flush(1'b1);
    do_read(32'h0000_1044, 4'd3, 0, 0);
    check_val("flush_miss", last_miss, 1'b1);
    check_stats("directed");

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) do_flush(1'($urandom));
      a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 6)
        | ($urandom & 32'h3F);
      do_read(a, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    check_stats("random");

    reset_in_mem_wait();
    do_read(32'h0000_1044, 4'd4, 0, 0);
    do_read(32'h0000_1048, 4'd4, 0, 0);
`ifdef GELATO_L1_CACHE_STATS_EN
    check_val("stats_hit1",  hit_count,  32'd1);
    check_val("stats_miss1", miss_count, 32'd1);
`else
    check_val("stats_hit0",  hit_count,  32'd0);
    check_val("stats_miss0", miss_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gelato_l1_cache_ctrl.md
Name: gelato_l1_cache_ctrl

Overview:
- Blocking, read-only, direct-mapped L1 cache controller between one warp's load/fetch requester and the shared memory port.
- Holds tag/valid/line arrays and sequences lookup, miss request, refill and response with an explicit FSM.
- Tags each request with a warp number and returns it with the response, so the requester can wake the correct warp.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word returned to requester.
- LINE_BITS, 512, cache line width (64 B); offset width OFF_W = log2(LINE_BITS/8) = 6.
- NUM_LINES, 64, direct-mapped sets; index width IDX_W = log2(NUM_LINES) = 6; tag width = ADDR_WIDTH-IDX_W-OFF_W = 20.
- WARP_W, 4, warp number width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  requester read request
- req_ready  output  1  controller can accept request
- req_addr  input  ADDR_WIDTH  byte address (word aligned; bits [1:0] ignored)
- req_warp  input  WARP_W  issuing warp number
- resp_valid  output  1  response data valid
- resp_ready  input  1  requester accepts response
- resp_data  output  DATA_WIDTH  requested word
- resp_warp  output  WARP_W  warp number of the response
- flush  input  1  invalidate all lines
- mem_req_valid  output  1  line fill request
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  ADDR_WIDTH  line-aligned address (offset bits zero)
- mem_resp_valid  input  1  fill line valid (single beat)
- mem_resp_data  input  LINE_BITS  fill line
- hit_count  output  32  hit counter (see Optional Feature)
- miss_count  output  32  miss counter (see Optional Feature)

Behaviour:
- Address split: tag=[ADDR_WIDTH-1:IDX_W+OFF_W], index=[IDX_W+OFF_W-1:OFF_W], word select=[OFF_W-1:2]; word w = line bits [32w+31:32w].
- Reset: state IDLE; all valid bits 0; req_ready=0 in the reset cycle, then 1; resp_valid, mem_req_valid, resp_data, resp_warp, mem_req_addr = 0; counters 0. Tag and data arrays are not reset.
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP.
- IDLE:
  - req_ready=1 only in IDLE.
  - If flush=1, clear all valid bits this cycle and stay in IDLE. Flush has priority; req_ready=0 that cycle, so a coincident request is not accepted.
  - Otherwise, on req_valid&req_ready, register addr and warp, then go to LOOKUP.
- LOOKUP:
  - Compare the stored tag against the registered tag under the valid bit.
  - Hit: load resp_data/resp_warp, go to RESP.
  - Miss: set mem_req_addr = {tag,index,0}, go to MEM_REQ.
- MEM_REQ: mem_req_valid=1, held with a stable address until mem_req_ready; then go to MEM_WAIT.
- MEM_WAIT:
  - On mem_resp_valid, write the line, write the tag, set valid, and load resp_data from mem_resp_data (not the array).
  - Then go to RESP.
  - mem_resp_valid is ignored in all other states.
- RESP: resp_valid=1, with data and warp stable until resp_ready; on handshake go to IDLE.
- Latency:
  - Hit: accept at cycle N, resp_valid at N+2.
  - Miss: resp_valid 1 cycle after mem_resp_valid.
  - A back-to-back request can be accepted 1 cycle after the resp handshake.
- flush outside IDLE is ignored. The requester holds flush until it observes req_ready.
- Reset mid-operation returns to IDLE and drops the in-flight request. A late memory response is discarded.
- A refill overwrites a conflicting line unconditionally; no write-back, since the cache is read-only.

Optional Feature:
- Macro: GELATO_L1_CACHE_STATS_EN.
- Defined:
  - hit_count increments in LOOKUP on a hit; miss_count increments in LOOKUP on a miss.
  - Both counters are 32-bit, wrap modulo 2^32, are cleared by rst, and are not cleared by flush.
- Undefined: hit_count and miss_count are tied to 0 and no counter registers are synthesized.

Test Plan:
- Cold miss:
  - Stimulus: after reset, read 0x0000_1044 warp 3.
  - Required: mem_req_addr=0x0000_1040; fill line with word k = 0xA000_0000+k; resp_data=0xA000_0001, resp_warp=3.
- Hit timing:
  - Stimulus: read 0x0000_1048 immediately after the cold miss.
  - Required: no mem_req_valid; resp_valid exactly 2 cycles after accept; resp_data=0xA000_0002.
- Conflict eviction:
  - Stimulus: read 0x0000_2040 (same index, different tag).
  - Required: miss to mem addr 0x0000_2040; a subsequent 0x0000_1040 read misses again.
- Backpressure:
  - Stimulus: hold mem_req_ready=0 for 5 cycles and resp_ready=0 for 4 cycles.
  - Required: mem_req_valid/addr and resp_valid/data/warp stable throughout; req_ready=0 until the resp handshake.
- Flush vs request:
  - Stimulus: assert flush and req_valid in the same IDLE cycle.
  - Required: request not accepted that cycle; next read of 0x0000_1044 misses.
- Reset in MEM_WAIT and stats:
  - Stimulus: assert rst during MEM_WAIT, then drive mem_resp_valid.
  - Required: no resp_valid and state IDLE. With GELATO_L1_CACHE_STATS_EN, after 1 miss + 1 hit, hit_count=1 and miss_count=1.
